// File: rtl/sq_dist_pkg.sv
// Shared constants and helpers for the squared-distance engine.
package sq_dist_pkg;

    // Beat mode as latched with each input beat.
    localparam logic MODE_NORM = 1'b0;
    localparam logic MODE_ACC  = 1'b1;

    // Ceiling log2, clog2(1) = 0.
    function automatic int clog2(input int unsigned value);
        int unsigned v;
        int          r;
        v = (value > 0) ? value - 1 : 0;
        r = 0;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

    // Group counter width, ACC_CNT_W = max(1, clog2(acc_len)).
    function automatic int acc_cnt_width(input int unsigned acc_len);
        int w;
        w = clog2(acc_len);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/cplx_sq_mag.sv
// Stages S1-S2 for one complex channel: register the inputs, then register
// the unsigned squares of the real and imaginary parts.
module cplx_sq_mag
    import sq_dist_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic signed [WIDTH-1:0] in_re,
    input  logic signed [WIDTH-1:0] in_im,
    output logic [2*WIDTH-2:0]      sq_re,
    output logic [2*WIDTH-2:0]      sq_im
);

    localparam int SQ_W = 2 * WIDTH - 1;

    logic signed [WIDTH-1:0]   re_q;
    logic signed [WIDTH-1:0]   im_q;
    logic signed [2*WIDTH-1:0] re_ext;
    logic signed [2*WIDTH-1:0] im_ext;
    logic signed [2*WIDTH-1:0] re_prod;
    logic signed [2*WIDTH-1:0] im_prod;

    // Full-width signed squares; (-2^(W-1))^2 still fits in 2W-1 unsigned bits.
    always_comb begin
        re_ext  = {{WIDTH{re_q[WIDTH-1]}}, re_q};
        im_ext  = {{WIDTH{im_q[WIDTH-1]}}, im_q};
        re_prod = re_ext * re_ext;
        im_prod = im_ext * im_ext;
    end

    // S1: input registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            re_q <= '0;
            im_q <= '0;
        end else if (en) begin
            re_q <= in_re;
            im_q <= in_im;
        end
    end

    // S2: square registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            sq_re <= '0;
            sq_im <= '0;
        end else if (en) begin
            sq_re <= SQ_W'(re_prod);
            sq_im <= SQ_W'(im_prod);
        end
    end

endmodule

// File: rtl/sq_dist_acc.sv
// Pipelined re^2 + im^2 engine for NCH channels with optional accumulation of
// ACC_LEN beats per group. Define SQDIST_SAT_EN to clamp results to all-ones
// and report out_sat; otherwise results wrap and out_sat is tied low.
module sq_dist_acc
    import sq_dist_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int NCH       = 4,
    parameter int ACC_LEN   = 4,
    parameter int OUT_WIDTH = 34
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     acc_mode,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [NCH*WIDTH-1:0]     in_re,
    input  logic [NCH*WIDTH-1:0]     in_im,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [NCH*OUT_WIDTH-1:0] out_dist,
    output logic [NCH-1:0]           out_sat
);

    localparam int SQ_W      = 2 * WIDTH - 1;
    // One guard bit above the larger of the sum and result widths.
    localparam int EXT_W     = ((OUT_WIDTH > 2 * WIDTH) ? OUT_WIDTH : 2 * WIDTH) + 1;
    localparam int ACC_CNT_W = acc_cnt_width(ACC_LEN);
    localparam logic [ACC_CNT_W-1:0] CNT_LAST = ACC_CNT_W'(ACC_LEN - 1);

    logic                     stall;
    logic                     en;
    logic                     s1_valid_q;
    logic                     s1_mode_q;
    logic                     s2_valid_q;
    logic                     s2_mode_q;
    logic [SQ_W-1:0]          sq_re [NCH];
    logic [SQ_W-1:0]          sq_im [NCH];
    logic [ACC_CNT_W-1:0]     acc_cnt_q;
    logic                     grp_mode_q;
    logic [OUT_WIDTH-1:0]     acc_q [NCH];
    logic [EXT_W-1:0]         total [NCH];
    logic [OUT_WIDTH-1:0]     res [NCH];
    logic                     eff_mode;
    logic                     first_beat;
    logic                     last_beat;
    logic                     out_valid_q;
    logic [NCH*OUT_WIDTH-1:0] out_dist_q;

    assign stall     = out_valid_q && !out_ready;
    assign en        = !stall;
    assign in_ready  = !stall && !rst;
    assign out_valid = out_valid_q;
    assign out_dist  = out_dist_q;

    for (genvar k = 0; k < NCH; k++) begin : g_ch
        cplx_sq_mag #(
            .WIDTH(WIDTH)
        ) u_sq (
            .clk  (clk),
            .rst  (rst),
            .en   (en),
            .in_re(in_re[k*WIDTH +: WIDTH]),
            .in_im(in_im[k*WIDTH +: WIDTH]),
            .sq_re(sq_re[k]),
            .sq_im(sq_im[k])
        );
    end

    // Valid and mode tags travel alongside the channel data through S1-S2.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_mode_q  <= MODE_NORM;
            s2_valid_q <= 1'b0;
            s2_mode_q  <= MODE_NORM;
        end else if (en) begin
            s1_valid_q <= in_valid;
            s1_mode_q  <= acc_mode;
            s2_valid_q <= s1_valid_q;
            s2_mode_q  <= s1_mode_q;
        end
    end

    // Group mode comes from the first beat; later beats' mode bits are ignored.
    always_comb begin
        eff_mode   = (acc_cnt_q == '0) ? s2_mode_q : grp_mode_q;
        first_beat = (eff_mode == MODE_NORM) || (acc_cnt_q == '0);
        last_beat  = (eff_mode != MODE_ACC) || (acc_cnt_q == CNT_LAST);
    end

`ifdef SQDIST_SAT_EN
    localparam logic [EXT_W-1:0] OUT_MAX = EXT_W'({OUT_WIDTH{1'b1}});

    logic [NCH-1:0] ovf;
    logic [NCH-1:0] res_sat;
    logic [NCH-1:0] acc_sat_q;
    logic [NCH-1:0] out_sat_q;

    // S3 sum with clamping; a clamped accumulator keeps its flag to group end.
    always_comb begin
        for (int k = 0; k < NCH; k++) begin
            total[k]   = (first_beat ? '0 : EXT_W'(acc_q[k])) + EXT_W'(sq_re[k])
                         + EXT_W'(sq_im[k]);
            ovf[k]     = total[k] > OUT_MAX;
            res[k]     = ovf[k] ? '1 : OUT_WIDTH'(total[k]);
            res_sat[k] = ovf[k] || (!first_beat && acc_sat_q[k]);
        end
    end

    // Saturation flags follow the accumulator and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_sat_q <= '0;
            out_sat_q <= '0;
        end else if (en && s2_valid_q) begin
            if (last_beat) begin
                out_sat_q <= res_sat;
            end else begin
                acc_sat_q <= res_sat;
            end
        end
    end

    assign out_sat = out_sat_q;
`else
    // S3 sum, wrapping modulo 2^OUT_WIDTH.
    always_comb begin
        for (int k = 0; k < NCH; k++) begin
            total[k] = (first_beat ? '0 : EXT_W'(acc_q[k])) + EXT_W'(sq_re[k])
                       + EXT_W'(sq_im[k]);
            res[k]   = OUT_WIDTH'(total[k]);
        end
    end

    assign out_sat = '0;
`endif

    // S3: group counter, accumulators and output register; all hold on stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_dist_q  <= '0;
            acc_cnt_q   <= '0;
            grp_mode_q  <= MODE_NORM;
            for (int k = 0; k < NCH; k++) begin
                acc_q[k] <= '0;
            end
        end else if (en) begin
            out_valid_q <= s2_valid_q && last_beat;
            if (s2_valid_q) begin
                if (acc_cnt_q == '0) begin
                    grp_mode_q <= s2_mode_q;
                end
                if (last_beat) begin
                    acc_cnt_q <= '0;
                    for (int k = 0; k < NCH; k++) begin
                        out_dist_q[k*OUT_WIDTH +: OUT_WIDTH] <= res[k];
                    end
                end else begin
                    acc_cnt_q <= acc_cnt_q + ACC_CNT_W'(1);
                    for (int k = 0; k < NCH; k++) begin
                        acc_q[k] <= res[k];
                    end
                end
            end
        end
    end

endmodule

// File: doc/sq_dist_acc.md
# sq_dist_acc

Pipelined, parametrised squared-magnitude engine for the sorter datapath. It computes re² + im² for NCH complex channels per beat. It can optionally accumulate ACC_LEN consecutive beats per channel to form partial Euclidean distances. A valid/ready handshake lets it sit directly between the symbol front-end and the sorter, which replaces the fixed four-channel combinational norm stage.

## Interface
- WIDTH, 16: signed two's-complement width of each real/imag input.
- NCH, 4: number of complex channels processed in parallel.
- ACC_LEN, 4: beats summed per group in accumulate mode; must be ≥ 1.
- OUT_WIDTH, 34: per-channel result width; 2*WIDTH + clog2(ACC_LEN) is lossless.
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- acc_mode  in  1  0 = per-beat norm; 1 = accumulate ACC_LEN beats.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat.
- in_re  in  NCH*WIDTH  packed real parts; channel k is at [k*WIDTH +: WIDTH].
- in_im  in  NCH*WIDTH  packed imaginary parts, same packing as in_re.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_dist  out  NCH*OUT_WIDTH  packed unsigned distances.
- out_sat  out  NCH  per-channel saturation flag.

## Operation
- A beat is accepted when in_valid && in_ready.
- Pipeline stages:
  - S1 registers the inputs.
  - S2 registers re² and im² per channel. These are unsigned, 2*WIDTH-1 bits; (-2^(W-1))² = 2^(2W-2) must be representable.
  - S3 adds the two squares (2*WIDTH bits) and updates the output and accumulator.
- Global stall: stall = out_valid && !out_ready.
  - When stall is high, every stage holds.
  - in_ready = !stall && !rst.
- Mode 0: each S3 beat loads out_dist and asserts out_valid.
- Mode 1, group counter acc_cnt (0..ACC_LEN-1) at S3:
  - On the first beat of a group (acc_cnt == 0), the accumulator loads the sum.
  - On subsequent beats, the accumulator adds the sum.
  - When acc_cnt == ACC_LEN-1, the final value moves to out_dist, out_valid asserts, and acc_cnt wraps to 0.
  - Non-final beats produce no out_valid.
- acc_mode is latched at S1 with each beat. The group mode is taken from the first beat of a group. A mode change mid-group is ignored until that group completes.
- ACC_LEN = 1 makes mode 1 identical to mode 0.
- Overflow beyond OUT_WIDTH is governed by the configuration macro (see Configuration).
- While out_valid && !out_ready, out_dist and out_sat are held stable.

## Timing
- Reset (synchronous, takes effect on the clk edge):
  - out_valid = 0, out_dist = 0, out_sat = 0.
  - acc_cnt = 0, accumulators = 0, all stage valids = 0.
  - in_ready = 0 while rst is high and 1 on the first cycle after.
- Latency: a beat accepted at edge t appears at out_valid on edge t+3 when there is no stall. In mode 1, latency is measured from the last beat of the group.
- Throughput: 1 beat/cycle when out_ready is held high.
- out_valid deasserts on the cycle after a handshake unless a new result lands on that same edge.
- Reset mid-group discards the partial sums. The next accepted beat starts a fresh group.
- A simultaneous out handshake and S3 completion loads the new result on the same edge with no bubble.

## Configuration
- SQDIST_SAT_EN defined:
  - An accumulated or summed value exceeding 2^OUT_WIDTH-1 clamps to all-ones.
  - The channel's out_sat bit is set for that result.
  - A saturated accumulator stays clamped until its group ends.
- SQDIST_SAT_EN undefined:
  - Results wrap modulo 2^OUT_WIDTH.
  - out_sat is tied to 0.
  - No comparator logic is generated.

## Structure
- Package sq_dist_pkg holds:
  - the clog2 function;
  - ACC_CNT_W = max(1, clog2(ACC_LEN));
  - the mode localparams MODE_NORM = 0 and MODE_ACC = 1.
- Sub-module cplx_sq_mag covers stages S1–S2 for one channel and is generated NCH times.
- Its enable comes from the shared stall signal.
- The top level owns the handshake, acc_cnt, the S3 adders, the accumulators and the saturation logic.

## Test plan
- Mode 0, WIDTH=16, one beat:
  - Stimulus: ch0=(3,4), ch1=(-32768,-32768), ch2=(0,0), ch3=(-1,1).
  - Required: out_dist = {25, 2147483648, 0, 2} exactly 3 cycles later.
- Mode 1, ACC_LEN=4, ch0 beats (1,1),(2,0),(0,3),(1,2):
  - Required: a single out_valid with ch0 = 20, 3 cycles after the 4th beat.
  - out_valid must not assert earlier.
- Backpressure: stream 10 beats in mode 0 with out_ready low for 5 cycles mid-stream.
  - in_ready drops while stalled and out_dist holds.
  - All 10 results arrive in order with none lost or duplicated.
- Reset after 2 of 4 beats in mode 1:
  - Then send 4 beats of (1,0).
  - Required: result = 4 and out_valid = 0 during reset.
- Saturation, OUT_WIDTH=32, ACC_LEN=4, all channels (-32768,-32768) for 4 beats (true sum 2^33):
  - With SQDIST_SAT_EN: out_dist = 0xFFFFFFFF and out_sat = 4'b1111.
  - Without it: out_dist = 0 and out_sat = 0.
- Mode change: toggle acc_mode to 0 on beat 2 of a mode-1 group.
  - The group still completes as an accumulation of 4.
  - The following beat is output individually.
